// File: rtl/iir_fold_sched_pkg.sv
// Shared encodings for the folded 2nd-order IIR scheduler: FSM states and tap indices.
package iir_fold_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Product order inside one output sample
  localparam int TAP_B0   = 0;  // b0 * x[n]
  localparam int TAP_B1   = 1;  // b1 * x[n-1]
  localparam int TAP_B2   = 2;  // b2 * x[n-2]
  localparam int TAP_A1   = 3;  // -a1 * y[n-1]
  localparam int TAP_A2   = 4;  // -a2 * y[n-2]
  localparam int IIR_TAPS = 5;

endpackage

// File: rtl/iir_fold_sched_if.sv
// Sample-in / result-out handshake between the source, the scheduler and the sink.
interface iir_fold_sched_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  // Source/sink side: offers samples, accepts results
  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  // Scheduler side
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/iir_fold_sched_step.sv
// Mod-TAPS step counter that walks the shared MAC through the products of one sample.
module fold_step_counter #(
  parameter int TAPS   = 5,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active low
  input  logic              clr,
  input  logic              en,
  output logic [STEP_W-1:0] step,
  output logic              last
);

  logic [STEP_W-1:0] step_reg;

  assign step = step_reg;
  assign last = (step_reg == STEP_W'(TAPS - 1));

  // Clear has priority over counting; the last step wraps back to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_reg <= '0;
    end else if (clr) begin
      step_reg <= '0;
    end else if (en) begin
      step_reg <= last ? '0 : step_reg + 1'b1;
    end
  end

endmodule

// File: rtl/iir_fold_sched.sv
// Control FSM of the folded 2nd-order IIR: sequences one shared MAC over the five
// products of each output sample and drives the datapath strobes and handshakes.
// No sample data passes through here.
module iir_fold_sched
  import iir_fold_pkg::*;
#(
  parameter int TAPS   = IIR_TAPS,
  parameter int STEP_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active low
  iir_fold_sched_if.slave   hs,
  input  logic              flush,
  output logic              sample_load,
  output logic [STEP_W-1:0] tap_sel,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_load,
  output logic              hist_shift,
  output logic              hist_clr,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt
);

  state_t            state_reg;
  state_t            state_next;
  logic [STEP_W-1:0] step;
  logic              step_last;
  logic              step_clr;
  logic              step_en;
  logic              cnt_inc;
  logic              in_ready_c;
  logic              out_valid_c;
  logic [CNT_W-1:0]  sample_cnt_reg;

  fold_step_counter #(
    .TAPS   (TAPS),
    .STEP_W (STEP_W)
  ) u_step (
    .clk  (clk),
    .rst  (rst),
    .clr  (step_clr),
    .en   (step_en),
    .step (step),
    .last (step_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and strobe decode; flush overrides everything and only clears history
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    sample_load = 1'b0;
    tap_sel     = '0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    out_load    = 1'b0;
    hist_shift  = 1'b0;
    hist_clr    = 1'b0;
    step_clr    = 1'b0;
    step_en     = 1'b0;
    cnt_inc     = 1'b0;
    if (flush) begin
      state_next = ST_IDLE;
      hist_clr   = 1'b1;
      step_clr   = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          in_ready_c  = 1'b1;
          sample_load = hs.in_valid;
          if (hs.in_valid) begin
            step_clr   = 1'b1;
            state_next = ST_MAC;
          end
        end
        ST_MAC: begin
          acc_en  = 1'b1;
          tap_sel = step;
          acc_clr = (step == '0);
          step_en = 1'b1;       // counter wraps to 0 on the last product
          if (step_last) begin
            state_next = ST_WB;
          end
        end
        ST_WB: begin
          out_load   = 1'b1;
          hist_shift = 1'b1;
          state_next = ST_HOLD;
        end
        ST_HOLD: begin
          out_valid_c = 1'b1;
          if (hs.out_ready) begin
            cnt_inc    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Completed-output counter; free-running wrap, untouched by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_reg <= '0;
    end else if (cnt_inc) begin
      sample_cnt_reg <= sample_cnt_reg + 1'b1;
    end
  end

  assign hs.in_ready  = in_ready_c;
  assign hs.out_valid = out_valid_c;
  assign busy         = (state_reg != ST_IDLE);
  assign sample_cnt   = sample_cnt_reg;

endmodule

// File: tb/tb_iir_fold_sched.sv
// Bench for iir_fold_sched: table of per-sample scenarios, hand-written timing,
// backpressure, burst and async-reset sequences, plus a handshake scoreboard.
module tb_iir_fold_sched;
  import iir_fold_pkg::*;

  localparam int TAPS   = IIR_TAPS;
  localparam int STEP_W = 3;
  localparam int CNT_W  = 8;          // narrow counter so the wrap is reachable quickly
  localparam int CMOD   = 1 << CNT_W;
  localparam int PERIOD = TAPS + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              sample_load;
  logic [STEP_W-1:0] tap_sel;
  logic              acc_clr;
  logic              acc_en;
  logic              out_load;
  logic              hist_shift;
  logic              hist_clr;
  logic              busy;
  logic [CNT_W-1:0]  sample_cnt;

  iir_fold_sched_if hs ();

  iir_fold_sched #(
    .TAPS   (TAPS),
    .STEP_W (STEP_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (hs),
    .flush       (flush),
    .sample_load (sample_load),
    .tap_sel     (tap_sel),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .out_load    (out_load),
    .hist_shift  (hist_shift),
    .hist_clr    (hist_clr),
    .busy        (busy),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int viol   = 0;
  int model_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int exp_cnt;
    int acc_cyc;
  } sb_t;
  sb_t sb_q[$];

  // Scoreboard/monitor: accept pushes the expected count, handshake pops it
  initial begin : mon
    bit pend    = 1'b0;
    int pend_cnt = 0;
    bit lat_done = 1'b0;
    bit prev_ov = 1'b0;
    bit prev_hs = 1'b0;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        sb_q.delete();
        pend = 1'b0; model_cnt = 0; lat_done = 1'b0; prev_ov = 1'b0; prev_hs = 1'b0;
      end else begin
        #2;
        if (pend) begin
          check("cnt_after_handshake", int'(sample_cnt), pend_cnt);
          model_cnt = pend_cnt;
          pend = 1'b0;
        end
        if (acc_en && hist_shift) viol++;
        if (hist_shift && hist_clr) viol++;
        if (!acc_en && tap_sel != '0) viol++;
        if (hs.out_valid && hs.in_ready) viol++;
        if (prev_ov && !prev_hs && !hs.out_valid && !flush) viol++;
        if (flush) begin
          sb_q.delete();
          lat_done = 1'b0;
        end else begin
          if (hs.out_valid && !lat_done && sb_q.size() > 0) begin
            check("latency", cyc - sb_q[0].acc_cyc, TAPS + 2);
            lat_done = 1'b1;
          end
          if (hs.out_valid && hs.out_ready) begin
            if (sb_q.size() == 0) check("unexpected_output", 1, 0);
            else begin
              pend_cnt = sb_q[0].exp_cnt;
              pend = 1'b1;
              void'(sb_q.pop_front());
              lat_done = 1'b0;
            end
          end
          if (sample_load) sb_q.push_back('{exp_cnt: (model_cnt + 1) % CMOD, acc_cyc: cyc});
        end
        prev_ov = hs.out_valid;
        prev_hs = hs.out_valid && hs.out_ready;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!busy) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  typedef struct {
    int rdy_wait;     // HOLD cycles before out_ready rises
    int flush_step;   // -1 none, 0..4 MAC step, 5 WB, 6 HOLD
    int exp_cycles;   // busy cycles after accept
    int exp_loads;
    int exp_clrs;
    int exp_dcnt;
  } vec_t;
  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    int c0, loads, clrs, cycles, hold_seen;
    bit flushed, do_flush;
    wait_idle();
    c0 = int'(sample_cnt);
    loads = 0; clrs = 0; cycles = 0; hold_seen = 0; flushed = 1'b0;
    hs.in_valid = 1'b1;
    hs.out_ready = 1'b0;
    @(negedge clk);
    hs.in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!busy) break;
      hs.out_ready = (hold_seen >= v.rdy_wait);
      do_flush = !flushed && v.flush_step >= 0 &&
                 ((v.flush_step <= 4 && acc_en && int'(tap_sel) == v.flush_step) ||
                  (v.flush_step == 5 && out_load) ||
                  (v.flush_step == 6 && hs.out_valid));
      if (hs.out_valid) hold_seen++;
      flush = do_flush;
      if (do_flush) flushed = 1'b1;
      #1;
      loads += int'(out_load);
      clrs  += int'(hist_clr);
      cycles++;
      @(negedge clk);
      flush = 1'b0;
    end
    hs.out_ready = 1'b0;
    check($sformatf("vec%0d_cycles", idx), cycles, v.exp_cycles);
    check($sformatf("vec%0d_out_load", idx), loads, v.exp_loads);
    check($sformatf("vec%0d_hist_clr", idx), clrs, v.exp_clrs);
    check($sformatf("vec%0d_cnt_delta", idx), (int'(sample_cnt) - c0 + CMOD) % CMOD, v.exp_dcnt);
  endtask

  task automatic burst(input int n);
    int accepts, last_acc, badsp;
    wait_idle();
    accepts = 0; last_acc = -1; badsp = 0;
    hs.in_valid = 1'b1;
    hs.out_ready = 1'b1;
    for (int i = 0; i < n * PERIOD + 20; i++) begin
      #1;
      if (sample_load) begin
        if (last_acc >= 0 && cyc - last_acc != PERIOD) badsp++;
        last_acc = cyc;
        accepts++;
      end
      @(negedge clk);
      if (accepts >= n) break;
    end
    hs.in_valid = 1'b0;
    wait_idle();
    hs.out_ready = 1'b0;
    check("burst_accepts", accepts, n);
    check("burst_spacing_errors", badsp, 0);
  endtask

  initial begin : stim
    int c0, bad;
    vecs[0] = '{rdy_wait: 0,  flush_step: -1, exp_cycles: 7,  exp_loads: 1, exp_clrs: 0, exp_dcnt: 1};
    vecs[1] = '{rdy_wait: 3,  flush_step: -1, exp_cycles: 10, exp_loads: 1, exp_clrs: 0, exp_dcnt: 1};
    vecs[2] = '{rdy_wait: 1,  flush_step: -1, exp_cycles: 8,  exp_loads: 1, exp_clrs: 0, exp_dcnt: 1};
    vecs[3] = '{rdy_wait: 0,  flush_step: 0,  exp_cycles: 1,  exp_loads: 0, exp_clrs: 1, exp_dcnt: 0};
    vecs[4] = '{rdy_wait: 0,  flush_step: 2,  exp_cycles: 3,  exp_loads: 0, exp_clrs: 1, exp_dcnt: 0};
    vecs[5] = '{rdy_wait: 0,  flush_step: 4,  exp_cycles: 5,  exp_loads: 0, exp_clrs: 1, exp_dcnt: 0};
    vecs[6] = '{rdy_wait: 0,  flush_step: 5,  exp_cycles: 6,  exp_loads: 0, exp_clrs: 1, exp_dcnt: 0};
    vecs[7] = '{rdy_wait: 2,  flush_step: 6,  exp_cycles: 7,  exp_loads: 1, exp_clrs: 1, exp_dcnt: 0};
    vecs[8] = '{rdy_wait: 0,  flush_step: -1, exp_cycles: 7,  exp_loads: 1, exp_clrs: 0, exp_dcnt: 1};

    hs.in_valid = 1'b0;
    hs.out_ready = 1'b0;
    rst = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    #1;
    check("rst_in_ready", int'(hs.in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(hs.out_valid), 0);
    check("rst_tap_sel", int'(tap_sel), 0);
    check("rst_sample_cnt", int'(sample_cnt), 0);
    rst = 1'b1;

    // Single sample timing
    wait_idle();
    c0 = int'(sample_cnt);
    hs.in_valid = 1'b1;
    hs.out_ready = 1'b1;
    #1;
    check("t0_sample_load", int'(sample_load), 1);
    @(negedge clk);
    hs.in_valid = 1'b0;
    for (int k = 1; k <= TAPS; k++) begin
      #1;
      check($sformatf("t%0d_tap_sel", k), int'(tap_sel), k - 1);
      check($sformatf("t%0d_acc_en", k), int'(acc_en), 1);
      check($sformatf("t%0d_acc_clr", k), int'(acc_clr), (k == 1) ? 1 : 0);
      @(negedge clk);
    end
    #1;
    check("t6_out_load", int'(out_load), 1);
    check("t6_hist_shift", int'(hist_shift), 1);
    check("t6_out_valid", int'(hs.out_valid), 0);
    @(negedge clk);
    #1;
    check("t7_out_valid", int'(hs.out_valid), 1);
    @(negedge clk);
    #1;
    check("t8_sample_cnt", int'(sample_cnt), (c0 + 1) % CMOD);
    check("t8_in_ready", int'(hs.in_ready), 1);
    hs.out_ready = 1'b0;

    // Scenario table
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Backpressure: 20 cycles held in HOLD
    wait_idle();
    hs.in_valid = 1'b1;
    hs.out_ready = 1'b0;
    @(negedge clk);
    hs.in_valid = 1'b1;        // offered while busy; must be ignored
    repeat (6) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!hs.out_valid || hs.in_ready || sample_load) bad++;
      @(negedge clk);
    end
    check("bp_hold_errors", bad, 0);
    hs.in_valid = 1'b0;
    c0 = int'(sample_cnt);
    hs.out_ready = 1'b1;
    #1;
    check("bp_out_valid", int'(hs.out_valid), 1);
    @(negedge clk);
    hs.out_ready = 1'b0;
    #1;
    check("bp_cnt", int'(sample_cnt), (c0 + 1) % CMOD);
    check("bp_idle", int'(busy), 0);
    check("bp_in_ready", int'(hs.in_ready), 1);

    // Back-to-back stream
    c0 = int'(sample_cnt);
    burst(2000);
    check("b2b_cnt", int'(sample_cnt), (c0 + 2000) % CMOD);

    // Async reset between edges in the middle of MAC
    wait_idle();
    hs.in_valid = 1'b1;
    hs.out_ready = 1'b1;
    @(negedge clk);
    hs.in_valid = 1'b0;
    @(posedge clk);
    #3;
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(hs.in_ready), 1);
    check("arst_tap_sel", int'(tap_sel), 0);
    check("arst_acc_en", int'(acc_en), 0);
    check("arst_sample_cnt", int'(sample_cnt), 0);
    rst = 1'b1;
    hs.out_ready = 1'b0;

    // Counter wrap at all-ones
    burst(CMOD - 1);
    check("cnt_max", int'(sample_cnt), CMOD - 1);
    burst(1);
    check("cnt_wrap", int'(sample_cnt), 0);

    repeat (3) @(negedge clk);
    check("invariants", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
